axi_lite_master_arbiter: RTL and testbench



---
 rtl/axi_lite_master_arbiter_pkg.sv | 29 ++
 rtl/axi_lite_master_arbiter_if.sv | 35 +++
 rtl/axi_lite_master_arbiter_rr_arbiter.sv | 55 +++++
 rtl/axi_lite_master_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi_lite_master_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_master_arbiter_pkg.sv
// Shared AXI-Lite parameters for the SoC master-side blocks.
// Holds the bus widths, response codes, the peripheral base map used by the
// on-chip requesters, and the state encoding of the master arbiter FSM.
package params_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Peripheral map behind the AXI-Lite interconnect.
  localparam logic [AXI_ADDR_W-1:0] UART_BASE  = 32'h4000_0000;
  localparam logic [AXI_ADDR_W-1:0] TIMER_BASE = 32'h4000_1000;
  localparam logic [AXI_ADDR_W-1:0] GPIO_BASE  = 32'h4000_2000;
  localparam logic [AXI_ADDR_W-1:0] REG_DATA   = 32'h0000_0000;

  // Arbiter FSM encoding, kept as fixed constants so the values match the
  // legacy register dumps.
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 3'd0;
  localparam arb_state_t ST_WRITE = 3'd1;
  localparam arb_state_t ST_WRESP = 3'd2;
  localparam arb_state_t ST_RADDR = 3'd3;
  localparam arb_state_t ST_RDATA = 3'd4;
  localparam arb_state_t ST_RSP   = 3'd5;

endpackage

// File: rtl/axi_lite_master_arbiter_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels).
// master: drives address/data/valids and the B/R readies.
// slave : drives the AW/W/AR readies and the B/R responses.
interface axi_lite_if;
  import params_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_master_arbiter_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req_i        : request vector
//   advance_i    : commit the current grant as the new last-grant pointer
//   grant_o      : combinational one-hot grant (all zero when no request)
//   grant_idx_o  : binary index of the granted requester
// The search starts one past the last granted index; the pointer resets to
// N-1 so index 0 wins the first arbitration.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx;
  logic          found;
  int unsigned   cand;

  always_comb begin
    grant_o = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
    if (found) grant_o[idx] = 1'b1;
  end

  assign grant_idx_o = idx;

  always_comb begin
    last_d = last_q;
    if (advance_i && found) last_d = idx;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= IW'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares the single AXI-Lite master port among NUM_REQ requesters. One
// single-beat transaction runs at a time; the issuing requester receives a
// one-cycle rsp_valid pulse with the read data and response code.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/req_write  : per-requester command valid and direction
//   req_addr/req_wdata   : per-requester command address and write data
//   req_ready            : one-hot accept strobe (combinational)
//   rsp_valid            : one-hot completion pulse
//   rsp_rdata/rsp_resp   : read data (0 for writes) and BRESP/RRESP
//   axi                  : shared AXI-Lite master port
module axi_lite_master_arbiter
  import params_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][AXI_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][AXI_DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [AXI_DATA_W-1:0]               rsp_rdata,
  output logic [1:0]                          rsp_resp,
  axi_lite_if.master                          axi
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_t            state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  accept;
  logic                  aw_hs, w_hs, rsp_fire;

  // Grants are only offered in idle and never while reset is held, so the
  // pointer cannot advance on a command that is about to be discarded.
  assign accept    = (state_q == ST_IDLE) && !reset && (|req_valid);
  assign req_ready = accept ? grant : '0;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign aw_hs    = awvalid_q && axi.awready;
  assign w_hs     = wvalid_q && axi.wready;
  // bready/rready are only high in their own states, so a handshake here
  // implies the matching state; stray responses elsewhere are ignored.
  assign rsp_fire = (bready_q && axi.bvalid) || (rready_q && axi.rvalid);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    owner_d     = owner_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr[grant_idx];
          wdata_d = req_wdata[grant_idx];
          write_d = req_write[grant_idx];
          owner_d = grant_idx;
          if (req_write[grant_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end

      ST_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end

      ST_RADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end

      ST_WRESP, ST_RDATA: begin
        if (rsp_fire) begin
          bready_d             = 1'b0;
          rready_d             = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = write_q ? '0 : axi.rdata;
          rsp_resp_d           = write_q ? axi.bresp : axi.rresp;
          state_d              = ST_RSP;
        end
      end

      ST_RSP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      owner_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      owner_q     <= owner_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign axi.awaddr  = addr_q;
  assign axi.araddr  = addr_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.arvalid = arvalid_q;
  assign axi.bready  = bready_q;
  assign axi.rready  = rready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter with a small AXI-Lite slave.
module tb_axi_lite_master_arbiter;
  import params_pkg::*;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;

  axi_lite_if bus ();

  axi_lite_master_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [0:15];
  logic        aw_seen, w_seen;
  logic        b_hold;
  logic        r_ovr;
  logic [31:0] r_ovr_data;
  logic [1:0]  rresp_cfg;
  logic [31:0] last_waddr, last_wdata;
  int          aw_cnt = 0;
  int          w_cnt  = 0;
  int          b_cnt  = 0;

  always @(posedge clk) begin
    if (reset) begin
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= 2'b00;
      aw_seen    <= 1'b0;
      w_seen     <= 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        aw_seen    <= 1'b1;
        aw_cnt     <= aw_cnt + 1;
        last_waddr <= bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
        w_seen     <= 1'b1;
        w_cnt      <= w_cnt + 1;
        last_wdata <= bus.wdata;
      end
      if (!bus.bvalid && !b_hold && (aw_seen || (bus.awvalid && bus.awready))
          && (w_seen || (bus.wvalid && bus.wready))) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= 2'b00;
        aw_seen    <= 1'b0;
        w_seen     <= 1'b0;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        b_cnt      <= b_cnt + 1;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= r_ovr ? r_ovr_data : mem[bus.araddr[5:2]];
        bus.rresp  <= r_ovr ? rresp_cfg : 2'b00;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_rsp(input int lim, output int cyc);
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [31:0] rd_addr [0:1][0:2];
  logic [31:0] rd_exp  [0:1][0:2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int owner;
    int cmd_k [2];
    int rsp_n [2];
    int gq [$];
    int b0, aw0, w0;

    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 + i;
    rd_addr[0][0] = 32'h00; rd_addr[0][1] = 32'h04; rd_addr[0][2] = 32'h08;
    rd_addr[1][0] = 32'h10; rd_addr[1][1] = 32'h14; rd_addr[1][2] = 32'h18;
    rd_exp[0][0] = 32'hA5A5_0000; rd_exp[0][1] = 32'hA5A5_0001; rd_exp[0][2] = 32'hA5A5_0002;
    rd_exp[1][0] = 32'hA5A5_0004; rd_exp[1][1] = 32'hA5A5_0005; rd_exp[1][2] = 32'hA5A5_0006;

    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1;
    b_hold = 1'b0; r_ovr = 1'b0; r_ovr_data = '0; rresp_cfg = 2'b00;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_valids", {29'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 32'd0);
    check("rst_readies", {30'd0, bus.bready, bus.rready}, 32'd0);
    check("rst_awaddr", bus.awaddr, 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_wstrb", {28'd0, bus.wstrb}, 32'hF);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    reset = 1'b0;

    // ---- test 1: zero-wait write from requester 0 ----
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0] = UART_BASE + REG_DATA; req_wdata[0] = 32'h48;
    #1 check("t1_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);                                          // cycle 1
    req_valid = 2'b00;
    check("t1_aw_w_valid", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    check("t1_awaddr", bus.awaddr, 32'h4000_0000);
    check("t1_wdata", bus.wdata, 32'h48);
    @(negedge clk);                                          // cycle 2
    check("t1_b_phase", {29'd0, bus.awvalid, bus.wvalid, bus.bready}, 32'd1);
    @(negedge clk);                                          // cycle 3
    check("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("t1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    check("t1_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);                                          // cycle 4
    check("t1_rsp_pulse", {30'd0, rsp_valid}, 32'd0);
    check("t1_slave_addr", last_waddr, 32'h4000_0000);
    check("t1_slave_data", last_wdata, 32'h48);

    // ---- test 2: both requesters valid from reset, 3 reads each ----
    reset = 1'b1;
    req_write = 2'b00;
    cmd_k[0] = 0; cmd_k[1] = 0; rsp_n[0] = 0; rsp_n[1] = 0;
    req_valid = 2'b11; req_addr[0] = rd_addr[0][0]; req_addr[1] = rd_addr[1][0];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (cmd_k[r] < 3) begin
          req_valid[r] = 1'b1;
          req_addr[r]  = rd_addr[r][cmd_k[r]];
        end else begin
          req_valid[r] = 1'b0;
        end
      end
      #1;
      if (rsp_valid != 2'b00) begin
        owner = rsp_valid[1] ? 1 : 0;
        check("t2_rsp_onehot", {30'd0, rsp_valid}, (owner == 1) ? 32'd2 : 32'd1);
        check("t2_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        if (rsp_n[owner] < 3) check("t2_rdata", rsp_rdata, rd_exp[owner][rsp_n[owner]]);
        rsp_n[owner]++;
      end
      for (int r = 0; r < 2; r++) begin
        if (req_ready[r]) begin
          gq.push_back(r);
          cmd_k[r]++;
        end
      end
      if (rsp_n[0] >= 3 && rsp_n[1] >= 3) break;
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("t2_grant_count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) check("t2_grant_order", 32'(gq[i]), 32'(i % 2));
    check("t2_rsp_count0", 32'(rsp_n[0]), 32'd3);
    check("t2_rsp_count1", 32'(rsp_n[1]), 32'd3);

    // ---- test 3: wready two cycles ahead of awready ----
    @(negedge clk);
    b0 = b_cnt; aw0 = aw_cnt; w0 = w_cnt;
    bus.awready = 1'b0; bus.wready = 1'b1;
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0] = GPIO_BASE + 32'h4; req_wdata[0] = 32'h0000_1234;
    #1 check("t3_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);                                          // cycle 1
    req_valid = 2'b00;
    check("t3_c1_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    @(negedge clk);                                          // cycle 2
    check("t3_w_drop_aw_hold", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
    @(negedge clk);                                          // cycle 3
    bus.awready = 1'b1;
    check("t3_c3_aw_hold", {30'd0, bus.awvalid, bus.bready}, 32'd2);
    @(negedge clk);                                          // cycle 4
    check("t3_c4_b_phase", {30'd0, bus.awvalid, bus.bready}, 32'd1);
    wait_rsp(10, cyc);
    check("t3_rsp_latency", 32'(cyc), 32'd1);
    check("t3_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    repeat (2) @(negedge clk);
    check("t3_b_count", 32'(b_cnt - b0), 32'd1);
    check("t3_aw_count", 32'(aw_cnt - aw0), 32'd1);
    check("t3_w_count", 32'(w_cnt - w0), 32'd1);
    check("t3_slave_data", last_wdata, 32'h0000_1234);

    // ---- test 4: SLVERR read for requester 1 ----
    r_ovr = 1'b1; r_ovr_data = 32'hDEAD_BEEF; rresp_cfg = 2'b10;
    req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 32'h20;
    #1 check("t4_ready", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    check("t4_arvalid", {31'd0, bus.arvalid}, 32'd1);
    wait_rsp(10, cyc);
    check("t4_rsp_latency", 32'(cyc), 32'd2);
    check("t4_rsp_owner", {30'd0, rsp_valid}, 32'd2);
    check("t4_rsp_resp", {30'd0, rsp_resp}, 32'h2);
    check("t4_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    r_ovr = 1'b0; rresp_cfg = 2'b00;
    @(negedge clk);
    check("t4_rsp_pulse", {30'd0, rsp_valid}, 32'd0);

    // ---- test 5: reset during write response wait ----
    @(negedge clk);
    b_hold = 1'b1;
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0] = TIMER_BASE; req_wdata[0] = 32'h5;
    #1 check("t5_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);                                          // cycle 1
    req_valid = 2'b00;
    @(negedge clk);                                          // cycle 2
    check("t5_wresp_wait", {30'd0, bus.bready, bus.bvalid}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("t5_valids_cleared",
          {27'd0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 32'd0);
    check("t5_no_rsp_in_reset", {30'd0, rsp_valid}, 32'd0);
    reset = 1'b0; b_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_rsp_after", {30'd0, rsp_valid}, 32'd0);
    end
    req_valid = 2'b11; req_write = 2'b00;
    req_addr[0] = 32'h0; req_addr[1] = 32'h4;
    #1 check("t5_first_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(10, cyc);
    check("t5_rsp_owner", {30'd0, rsp_valid}, 32'd1);
    check("t5_rsp_rdata", rsp_rdata, 32'hA5A5_0000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
